// File: rtl/regbank_writer.sv
// Write side of the general register bank: in-order pending-write queue feeding
// one commit per cycle into register storage, with read-after-write hazard flags.
module regbank_writer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned NREGS  = 62,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    hold,
  input  logic [ADDR_W-1:0]       chk_a,
  input  logic [ADDR_W-1:0]       chk_b,
  output logic                    haz_a,
  output logic                    haz_b,
  output logic [NREGS*DATA_W-1:0] regs_flat,
  output logic                    commit_pulse,
  output logic [ADDR_W-1:0]       commit_addr,
  output logic                    idle
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0]   DepthC  = CntW'(DEPTH);
  localparam logic [ADDR_W-1:0] NregsA  = ADDR_W'(NREGS);
  localparam logic [PtrW-1:0]   LastPtr = PtrW'(DEPTH - 1);

  logic [ADDR_W-1:0] q_addr [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [PtrW-1:0]   head_q, tail_q;
  logic [CntW-1:0]   count_q;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DEPTH-1:0]  slot_valid;
  logic              accept, commit;

  function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on registered occupancy, never on hold or this cycle's commit.
  assign wr_ready = (count_q < DepthC) && !reset;
  assign accept   = wr_valid && wr_ready;
  assign commit   = (count_q != '0) && !hold;
  assign idle     = (count_q == '0);

  always_comb begin
    slot_valid = '0;
    haz_a      = 1'b0;
    haz_b      = 1'b0;
    for (int s = 0; s < int'(DEPTH); s++) begin
      // Slot s holds a live entry when its distance from head is below count.
      slot_valid[s] = ((s + int'(DEPTH) - int'(head_q)) % int'(DEPTH)) < int'(count_q);
      if (slot_valid[s] && (chk_a < NregsA) && (q_addr[s] == chk_a)) haz_a = 1'b1;
      if (slot_valid[s] && (chk_b < NregsA) && (q_addr[s] == chk_b)) haz_b = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      commit_pulse <= 1'b0;
      commit_addr  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_addr[i] <= '0;
        q_data[i] <= '0;
      end
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else begin
      if (accept) begin
        q_addr[tail_q] <= wr_addr;
        q_data[tail_q] <= wr_data;
        tail_q         <= inc_ptr(tail_q);
      end
      if (commit) begin
        head_q      <= inc_ptr(head_q);
        commit_addr <= q_addr[head_q];
        // Addresses at or above NREGS match no register and are dropped.
        for (int i = 0; i < int'(NREGS); i++) begin
          if (q_addr[head_q] == ADDR_W'(i)) regs_q[i] <= q_data[head_q];
        end
      end
      commit_pulse <= commit;
      if (accept && !commit)      count_q <= count_q + 1'b1;
      else if (!accept && commit) count_q <= count_q - 1'b1;
    end
  end

  for (genvar g = 0; g < int'(NREGS); g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

endmodule
